uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 171 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter; rate and byte are latched per frame.
// Define UART_TX_PARITY_EN to append an even parity bit (11-bit frame).
module uart_transmitter #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  input  logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int unsigned div_of(input int unsigned baud);
    int unsigned d;
    d = (CLK_HZ + 8 * baud) / (16 * baud);
    return (d == 0) ? 32'd1 : d;
  endfunction

  localparam int unsigned DMAX = div_of(300);
  localparam int DW = $clog2(DMAX + 1);

  localparam logic [DW-1:0] DIV0 = DW'(div_of(300));
  localparam logic [DW-1:0] DIV1 = DW'(div_of(1200));
  localparam logic [DW-1:0] DIV2 = DW'(div_of(4800));
  localparam logic [DW-1:0] DIV3 = DW'(div_of(9600));
  localparam logic [DW-1:0] DIV4 = DW'(div_of(19200));
  localparam logic [DW-1:0] DIV5 = DW'(div_of(38400));
  localparam logic [DW-1:0] DIV6 = DW'(div_of(57600));
  localparam logic [DW-1:0] DIV7 = DW'(div_of(115200));

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    baud_q, baud_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] div_sel;
  logic [3:0]    tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;
  logic          tick;
  logic          bit_end;

  always_comb begin
    div_sel = DIV7;
    unique case (baud_q)
      3'd0: div_sel = DIV0;
      3'd1: div_sel = DIV1;
      3'd2: div_sel = DIV2;
      3'd3: div_sel = DIV3;
      3'd4: div_sel = DIV4;
      3'd5: div_sel = DIV5;
      3'd6: div_sel = DIV6;
      3'd7: div_sel = DIV7;
    endcase
  end

  assign accept  = (state_q == IDLE) && Tx_WR && Tx_EN && !busy_q;
  assign tick    = (div_q == div_sel - DW'(1));
  assign bit_end = tick && (tick_q == 4'd15);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    baud_d  = baud_q;
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) tick_d = tick_q + 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          data_d  = Tx_DATA;
          baud_d  = baud_select;
          div_d   = '0;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // line level trails the state register by one clock
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_q[bit_q];
      PARITY:  txd_d = ^data_q;
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      baud_q  <= '0;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;
  assign Tx_DONE = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for uart_transmitter.
// Honours UART_TX_PARITY_EN for the expected frame length.
module tb_uart_transmitter;

  localparam int unsigned CLK_HZ = 50000000;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       Tx_EN;
  logic [2:0] baud_select;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  uart_transmitter #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .Tx_DATA    (Tx_DATA),
    .Tx_WR      (Tx_WR),
    .Tx_EN      (Tx_EN),
    .baud_select(baud_select),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY),
    .Tx_DONE    (Tx_DONE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         bc;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_done = 0;
  int   last_done = -100;
  bit   abort_frame = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // clocks per bit from the nominal rate table
  function automatic int bit_clks(input logic [2:0] bs);
    int  rates[8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    real d;
    d = CLK_HZ / (16.0 * rates[bs]);
    return 16 * $rtoi(d + 0.5);
  endfunction

  function automatic int exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 0;
    if (i <= 8) return int'(d[i-1]);
    if (NB == 11 && i == 9) return $countones(d) % 2;
    return 1;
  endfunction

  task automatic check_frame();
    exp_t e;
    int   t0;
    int   guard;
    t0 = cyc;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_start: TxD fell at cycle %0d, expected none", t0);
      return;
    end
    e = sb.pop_front();
    if (e.gap >= 0) chk("b2b_gap", t0 - last_done, e.gap);
    for (int i = 0; i < NB; i++) begin
      while (cyc < t0 + i * e.bc + e.bc / 2) @(negedge clk);
      chk($sformatf("bit%0d_of_%02h", i, e.data), int'(TxD), exp_bit(e.data, i));
    end
    chk("busy_in_frame", int'(Tx_BUSY), 1);
    guard = 0;
    while (!Tx_DONE && guard < e.bc) begin
      @(negedge clk);
      guard++;
    end
    chk("done_cycle", cyc - t0, NB * e.bc - 1);
    chk("busy_at_done", int'(Tx_BUSY), 0);
    last_done = cyc;
    @(negedge clk);
    chk("done_width", int'(Tx_DONE), 0);
    frames_done++;
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !TxD) begin
        if (abort_frame) wait (!rst_n);
        else check_frame();
      end
      prev = rst_n ? TxD : 1'b1;
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] bs);
    int g;
    g = 0;
    while (Tx_BUSY && g < 100000) begin
      @(negedge clk);
      g++;
    end
    Tx_DATA     = d;
    baud_select = bs;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    sb.push_back('{d, bit_clks(bs), -1});
    @(negedge clk);
    Tx_WR = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int g;
    g = 0;
    while (frames_done < n && g < 80000) begin
      @(negedge clk);
      g++;
    end
    chk("frames_completed", frames_done, n);
  endtask

  initial begin : stim
    int n;
    int g;
    int bad;
    Tx_DATA     = '0;
    Tx_WR       = 1'b0;
    Tx_EN       = 1'b0;
    baud_select = '0;
    repeat (3) @(negedge clk);
    chk("reset_txd", int'(TxD), 1);
    chk("reset_busy", int'(Tx_BUSY), 0);
    chk("reset_done", int'(Tx_DONE), 0);
    rst_n = 1'b1;
    @(negedge clk);
    n = 0;

    // 0x55 then 0x0F launched from the done cycle
    send(8'h55, 3'b111);
    n++;
    g = 0;
    while (!Tx_DONE && g < 10000) begin
      @(negedge clk);
      g++;
    end
    Tx_DATA = 8'h0F;
    Tx_EN   = 1'b1;
    Tx_WR   = 1'b1;
    sb.push_back('{8'h0F, bit_clks(3'b111), 2});
    @(negedge clk);
    Tx_WR = 1'b0;
    n++;
    wait_frames(n);

    // write while busy is dropped
    send(8'h01, 3'b111);
    n++;
    repeat (1000) @(negedge clk);
    Tx_DATA = 8'hAA;
    Tx_WR   = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    wait_frames(n);

    // write while disabled is dropped
    Tx_EN   = 1'b0;
    Tx_DATA = 8'hAA;
    Tx_WR   = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
    end
    Tx_WR = 1'b0;
    Tx_EN = 1'b1;
    chk("en_low_ignored", bad, 0);

    send(8'($urandom), 3'b111);
    n++;
    wait_frames(n);

    // reset in the middle of a frame
    abort_frame = 1'b1;
    Tx_DATA     = 8'($urandom);
    baud_select = 3'b111;
    Tx_WR       = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    repeat ($urandom_range(50, 3000)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txd", int'(TxD), 1);
    chk("abort_busy", int'(Tx_BUSY), 0);
    chk("abort_done", int'(Tx_DONE), 0);
    repeat (3) @(negedge clk);
    rst_n       = 1'b1;
    abort_frame = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    send(8'($urandom), 3'b111);
    n++;
    wait_frames(n);

    // rate and enable change mid-frame must not disturb it
    send(8'($urandom), 3'b011);
    n++;
    repeat (2000) @(negedge clk);
    baud_select = 3'b111;
    Tx_EN       = 1'b0;
    wait_frames(n);
    Tx_EN = 1'b1;

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
